// File: rtl/data_memory_stage.sv
// Multi-cycle word data memory behind the ALU: captures one load/store, holds the CPU via stall
// for LATENCY+1 cycles, then pulses mem_done. Optional alignment checking via DMEM_ALIGN_CHECK_EN.
module data_memory_stage #(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        mem_done,
    output logic        misaligned,
    output logic [1:0]  dbg_state
);

    // Handshake: a request (mem_read|mem_write) seen in IDLE is accepted at that edge; the CPU keeps
    // it steady while stall is high, and mem_done marks the single cycle in which the result is valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  counter;
    logic [ADDR_W-1:0] cap_idx;
    logic [31:0]       cap_data;
    logic              cap_read, cap_write, cap_misal;
    logic              req, last_beat, bad_addr;
    logic [31:0]       mem [DEPTH];
    logic              unused_addr_bits;

    assign req       = mem_read | mem_write;
    assign last_beat = (state == BUSY) && (counter == '0);
    assign stall     = ((state == IDLE) && req) || (state == BUSY);
    assign dbg_state = state;
    assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign bad_addr = |addr[1:0];
`else
    assign bad_addr = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req) state_nxt = BUSY;
            BUSY:    if (counter == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            counter    <= '0;
            read_data  <= '0;
            mem_done   <= 1'b0;
            misaligned <= 1'b0;
            cap_idx    <= '0;
            cap_data   <= '0;
            cap_read   <= 1'b0;
            cap_write  <= 1'b0;
            cap_misal  <= 1'b0;
        end else begin
            state      <= state_nxt;
            mem_done   <= last_beat;
            misaligned <= last_beat && cap_misal;
            if ((state == IDLE) && req) begin
                counter   <= CNT_INIT;
                cap_idx   <= addr[ADDR_W+1:2];
                cap_data  <= write_data;
                cap_read  <= mem_read;
                cap_write <= mem_write;
                cap_misal <= bad_addr;
            end else if ((state == BUSY) && (counter != '0)) begin
                counter <= counter - CNT_W'(1);
            end
            // Read+write together forwards the store data; a pure store leaves read_data alone.
            if (last_beat && cap_read) begin
                if (cap_misal)      read_data <= '0;
                else if (cap_write) read_data <= cap_data;
                else                read_data <= mem[cap_idx];
            end
        end
    end

    // Array is never cleared; reset forces IDLE so an in-flight store can't land.
    always_ff @(posedge clk) begin
        if (last_beat && cap_write && !cap_misal)
            mem[cap_idx] <= cap_data;
    end

endmodule

// File: tb/tb_data_memory_stage.sv
// Directed bench for data_memory_stage (LATENCY=2): timing of stall/mem_done, aliasing,
// read+write priority, reset abort, input capture, and alignment behaviour.
module tb_data_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] addr, write_data;
    logic [31:0] read_data;
    logic        stall, mem_done, misaligned;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam logic EXP_MIS = 1'b1;
`else
    localparam logic EXP_MIS = 1'b0;
`endif

    data_memory_stage #(.DEPTH(1024), .ADDR_W(10), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .stall      (stall),
        .mem_done   (mem_done),
        .misaligned (misaligned),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while IDLE; returns at the negedge of the DONE cycle with the request
    // still held. Mid-BUSY the address/data are disturbed to prove the captured copy is used.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] a_mid, input logic exp_mis);
        mem_read   = rd;
        mem_write  = wr;
        addr       = a;
        write_data = d;
        #1;
        chk({tag, " stall c0"}, stall, 1);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk({tag, " stall busy"}, stall, 1);
            chk({tag, " done busy"}, mem_done, 0);
            if (c == 1) begin
                addr       = a_mid;
                write_data = ~d;
            end
        end
        @(negedge clk);
        chk({tag, " stall done"}, stall, 0);
        chk({tag, " mem_done"}, mem_done, 1);
        chk({tag, " misaligned"}, misaligned, exp_mis);
        chk({tag, " state done"}, dbg_state, 2'd2);
    endtask

    task automatic go_idle(input string tag);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        chk({tag, " idle done"}, mem_done, 0);
        chk({tag, " idle stall"}, stall, 0);
        chk({tag, " idle mis"}, misaligned, 0);
    endtask

    initial begin
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = '0; write_data = '0;
        @(negedge clk);
        chk("rst read_data", read_data, 32'h0);
        chk("rst mem_done", mem_done, 0);
        chk("rst misaligned", misaligned, 0);
        chk("rst stall", stall, 0);
        chk("rst state", dbg_state, 2'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: store then load at 0x10
        run_access("t1 st", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h10, 1'b0);
        chk("t1 st rdata", read_data, 32'h0);
        go_idle("t1 st");
        run_access("t1 ld", 1'b1, 1'b0, 32'h10, 32'h0, 32'h10, 1'b0);
        chk("t1 ld rdata", read_data, 32'hDEADBEEF);
        go_idle("t1 ld");

        // 2: 0x1000 aliases word 0
        run_access("t2 st", 1'b0, 1'b1, 32'h1000, 32'h12345678, 32'h1000, 1'b0);
        chk("t2 st rdata hold", read_data, 32'hDEADBEEF);
        go_idle("t2 st");
        run_access("t2 ld", 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("t2 ld rdata", read_data, 32'h12345678);
        go_idle("t2 ld");

        // 3: read+write together
        run_access("t3 rw", 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 32'h20, 1'b0);
        chk("t3 rw rdata", read_data, 32'hA5A5A5A5);
        go_idle("t3 rw");
        run_access("t3 ld", 1'b1, 1'b0, 32'h20, 32'h0, 32'h20, 1'b0);
        chk("t3 ld mem8", read_data, 32'hA5A5A5A5);
        go_idle("t3 ld");

        // 4: reset in first BUSY cycle aborts a store
        run_access("t4 pre", 1'b0, 1'b1, 32'h30, 32'h1, 32'h30, 1'b0);
        go_idle("t4 pre");
        mem_write = 1'b1; addr = 32'h30; write_data = 32'hFFFFFFFF;
        @(negedge clk);
        chk("t4 busy state", dbg_state, 2'd1);
        rst = 1'b0;
        #1;
        chk("t4 rst rdata", read_data, 32'h0);
        chk("t4 rst state", dbg_state, 2'd0);
        chk("t4 rst done", mem_done, 0);
        mem_write = 1'b0;
        #1;
        chk("t4 rst stall", stall, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4 post done", mem_done, 0);
            chk("t4 post stall", stall, 0);
        end
        run_access("t4 ld", 1'b1, 1'b0, 32'h30, 32'h0, 32'h30, 1'b0);
        chk("t4 ld rdata", read_data, 32'h1);
        go_idle("t4 ld");

        // 5: address change mid-BUSY, request held through DONE
        run_access("t5 ld", 1'b1, 1'b0, 32'h10, 32'h0, 32'h20, 1'b0);
        chk("t5 ld rdata", read_data, 32'hDEADBEEF);
        @(negedge clk);
        chk("t5 after done state", dbg_state, 2'd0);
        chk("t5 after done pulse", mem_done, 0);
        chk("t5 idle req stall", stall, 1);
        mem_read = 1'b0;
        @(negedge clk);
        chk("t5 no new access", dbg_state, 2'd0);
        chk("t5 quiet stall", stall, 0);

        // 6: misaligned store to 0x13
        run_access("t6 st", 1'b0, 1'b1, 32'h13, 32'h11111111, 32'h13, EXP_MIS);
        chk("t6 st rdata hold", read_data, 32'hDEADBEEF);
        go_idle("t6 st");
        run_access("t6 ld", 1'b1, 1'b0, 32'h10, 32'h0, 32'h10, 1'b0);
        chk("t6 word 0x10", read_data, EXP_MIS ? 32'hDEADBEEF : 32'h11111111);
        go_idle("t6 ld");
        run_access("t6 mld", 1'b1, 1'b0, 32'h12, 32'h0, 32'h12, EXP_MIS);
        chk("t6 misaligned ld", read_data, EXP_MIS ? 32'h0 : (EXP_MIS ? 32'hDEADBEEF : 32'h11111111));
        go_idle("t6 mld");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_stage.md
Name: data_memory_stage

Overview:
Word-organised data memory that sits directly downstream of the single-cycle CPU's ALU.
- Consumes the ALU result as a byte address and the second register read value as store data.
- Produces load data for the MemtoReg writeback mux.
- Models a multi-cycle memory with configurable latency. A stall output holds the PC while an access is in flight.

Parameters:
DEPTH, 1024, number of 32-bit words (power of two)
ADDR_W, 10, log2(DEPTH); word index width
LATENCY, 2, cycles spent in BUSY per access (must be >= 1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
mem_read  input  1  load request (Control MemRead)
mem_write  input  1  store request (Control MemWrite)
addr  input  32  byte address from ALU result
write_data  input  32  store data (register read port 2)
read_data  output  32  registered load data to writeback mux
stall  output  1  combinational; high = CPU must hold PC and register writes
mem_done  output  1  registered; one-cycle pulse marking access completion
misaligned  output  1  registered; alignment error flag, valid with mem_done

Behaviour:
Reset (rst low, asynchronous):
- Outputs: state=IDLE, counter=0, read_data=0, mem_done=0, misaligned=0.
- Memory array is not cleared.
- An in-flight write is aborted and memory is unchanged.
- stall follows the combinational rule below immediately after reset releases.

Addressing:
- Word index = addr[ADDR_W+1:2].
- addr[31:ADDR_W+2] is ignored, so addresses alias modulo DEPTH*4.

States:
- IDLE:
  - If mem_read or mem_write is high at a rising edge, capture addr, write_data and op, then go to BUSY.
  - Load counter with LATENCY-1.
  - No request: remain in IDLE.
- BUSY:
  - counter != 0: decrement.
  - counter == 0: perform the access at this edge and go to DONE.
    - Store: mem[index] <= captured data.
    - Load: read_data <= mem[index].
- DONE:
  - mem_done=1 for exactly this cycle; read_data valid.
  - Unconditionally returns to IDLE next edge.
  - mem_read and mem_write are ignored in this cycle, because the CPU advances the PC at the end of DONE.

stall, combinational:
- High when (IDLE and (mem_read | mem_write)) or BUSY.
- Low in DONE and in idle cycles with no request.

Latency:
- Request first seen in cycle 0 (IDLE).
- BUSY occupies cycles 1..LATENCY.
- DONE is cycle LATENCY+1.
- Total CPU hold is LATENCY+1 stalled cycles.

Data-path rules:
- Simultaneous mem_read and mem_write: treated as a store (write priority), and read_data is also loaded with the captured write_data.
- read_data holds its last value between loads; stores do not change it, except in the simultaneous case above.
- Request inputs changing during BUSY are ignored; the captured values are used.
- Back-to-back accesses: the next request is sampled in the IDLE cycle after DONE. There is no pipelining.

Optional Feature:
Macro DMEM_ALIGN_CHECK_EN.
- Defined:
  - If captured addr[1:0] != 0, the access still takes the full latency.
  - A store is suppressed (memory unchanged).
  - A load returns read_data=0.
  - misaligned=1 in the DONE cycle, alongside mem_done; 0 otherwise.
- Undefined:
  - addr[1:0] is ignored (access goes to the word at addr[ADDR_W+1:2]).
  - misaligned is tied to 0.

Test Plan:
1. LATENCY=2: store 0xDEADBEEF to addr 0x10, then load from 0x10.
   - stall high 3 cycles per access.
   - mem_done pulses in the 4th cycle of each access.
   - read_data=0xDEADBEEF.
2. Wrap-around: store 0x12345678 to addr 0x1000 (DEPTH 1024), load addr 0x0.
   - read_data=0x12345678.
3. Simultaneous mem_read=1 and mem_write=1, addr 0x20, data 0xA5A5A5A5.
   - mem[8]=0xA5A5A5A5 and read_data=0xA5A5A5A5 at DONE.
4. Reset asserted in the first BUSY cycle of a store of 0xFFFFFFFF to addr 0x30 (which previously held 0x1).
   - read_data=0, stall low once requests drop, no mem_done.
   - A subsequent load of 0x30 returns 0x1.
5. Inputs change during BUSY: load from 0x10, then switch addr to 0x20 mid-BUSY.
   - Result reflects 0x10.
   - Request held high in the DONE cycle causes no new access until IDLE.
6. With DMEM_ALIGN_CHECK_EN: store 0x11111111 to addr 0x13.
   - misaligned=1 with mem_done; word at 0x10 unchanged.
   - Without the macro: word at 0x10 becomes 0x11111111 and misaligned stays 0.
